// File: rtl/ethpipe_pkg.sv
// Shared ethpipe definitions: TX engine state encoding, GMII framing bytes,
// CRC-32 constants and default frame-size limits.
package ethpipe_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_DATA, ST_PAD, ST_FCS, ST_GAP, ST_DROP, ST_DONE
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;  // reflected 0x04C11DB7

  localparam int MIN_LEN_DEF = 60;
  localparam int MAX_LEN_DEF = 1514;
  localparam int IFG_DEF     = 12;
endpackage

// File: rtl/tx_slot2gmii_if.sv
// Slot-RAM + GMII bundle for one ethpipe TX port.
//   slot_ready : host filled the slot (sys_clk domain level)
//   slot_done  : one-cycle pulse, slot may be released
//   ram_addr   : slot RAM word address, ram_q arrives one cycle later
//   gmii_txd / gmii_tx_en : GMII transmit pins
interface tx_slot2gmii_if;
  logic        slot_ready;
  logic        slot_done;
  logic [11:0] ram_addr;
  logic [15:0] ram_q;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;

  modport master (input slot_ready, ram_q,
                  output slot_done, ram_addr, gmii_txd, gmii_tx_en);
  modport slave  (output slot_ready, ram_q,
                  input slot_done, ram_addr, gmii_txd, gmii_tx_en);
endinterface

// File: rtl/crc32_d8.sv
// Combinational one-byte update of the reflected IEEE 802.3 CRC-32.
//   crc_in : running CRC register
//   d      : next byte (LSB is the first bit on the wire)
//   crc_out: register after absorbing d
module crc32_d8
  import ethpipe_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);
  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    crc_out = c;
  end
endmodule

// File: rtl/tx_slot2gmii.sv
// TX slot -> GMII engine. Reads a host-filled slot (word 0 = length,
// then big-endian byte pairs), sends preamble/SFD, data, zero pad to
// MIN_LEN, FCS, then holds IFG idle byte times before pulsing slot_done.
// Oversize slots are dropped without GMII activity.
//   sys_clk/sys_rst_n : 125 MHz GMII clock, async active-low reset
//   tx_enable         : gates only the start of a new frame
//   bus               : slot RAM + GMII signals (master side)
//   tx_busy           : not idle
//   tx_frames/tx_drops: sent-frame counter (wraps), drop counter (saturates)
module tx_slot2gmii
  import ethpipe_pkg::*;
#(
  parameter int IFG     = IFG_DEF,
  parameter int MIN_LEN = MIN_LEN_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           tx_enable,
  tx_slot2gmii_if.master bus,
  output logic           tx_busy,
  output logic [31:0]    tx_frames,
  output logic [15:0]    tx_drops
);
  tx_state_e   state_q, state_d;
  logic [10:0] cnt_q, cnt_d, len_q, len_d;
  logic [15:0] wcur_q, wcur_d, wnxt_q, wnxt_d;
  logic [31:0] crc_q, crc_d, crc_next, crc_fcs;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  txd_q, txd_d, byte_sel, crc_byte;
  logic        txen_q, txen_d, done_q, done_d;
  logic [31:0] frames_q, frames_d;
  logic [15:0] drops_q, drops_d;
  // Low for the first cycle after reset: ram_q does not yet reflect word 0.
  logic        prime_q;

  assign byte_sel = cnt_q[0] ? wcur_q[7:0] : wcur_q[15:8];
  assign crc_byte = (state_q == ST_DATA) ? byte_sel : 8'h00;
  assign crc_fcs  = ~crc_q;

  crc32_d8 u_crc (.crc_in(crc_q), .d(crc_byte), .crc_out(crc_next));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    wcur_d   = wcur_q;
    wnxt_d   = wnxt_q;
    crc_d    = crc_q;
    addr_d   = 12'd0;
    txd_d    = 8'h00;
    txen_d   = 1'b0;
    done_d   = 1'b0;
    frames_d = frames_q;
    drops_d  = drops_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_enable && bus.slot_ready && prime_q) begin
          len_d = bus.ram_q[10:0];
          if (bus.ram_q[10:0] > 11'(MAX_LEN)) begin
            state_d = ST_DROP;
          end else begin
            state_d = ST_PRE;
            txd_d   = PREAMBLE_BYTE;
            txen_d  = 1'b1;
            cnt_d   = 11'd1;
            addr_d  = 12'd1;
            crc_d   = CRC_INIT;
          end
        end
      end
      ST_PRE: begin
        // Prefetch: addresses 1,2,3 issued on the first preamble cycles;
        // words 1 and 2 land in the two buffers, word 3 is on ram_q at
        // the first odd data byte.
        txen_d = 1'b1;
        addr_d = (cnt_q < 11'd3) ? addr_q + 12'd1 : addr_q;
        if (cnt_q == 11'd2) wcur_d = bus.ram_q;
        if (cnt_q == 11'd3) wnxt_d = bus.ram_q;
        if (cnt_q == 11'd7) begin
          txd_d   = SFD_BYTE;
          cnt_d   = 11'd0;
          state_d = (len_q == 11'd0) ? ST_PAD : ST_DATA;
        end else begin
          txd_d = PREAMBLE_BYTE;
          cnt_d = cnt_q + 11'd1;
        end
      end
      ST_DATA: begin
        txen_d = 1'b1;
        txd_d  = byte_sel;
        crc_d  = crc_next;
        cnt_d  = cnt_q + 11'd1;
        addr_d = addr_q;
        // Low byte done: rotate buffers and pull the next word every 2 cycles.
        if (cnt_q[0]) begin
          wcur_d = wnxt_q;
          wnxt_d = bus.ram_q;
          addr_d = addr_q + 12'd1;
        end
        if (cnt_q == len_q - 11'd1) begin
          if (len_q < 11'(MIN_LEN)) begin
            state_d = ST_PAD;          // cnt keeps counting bytes sent
          end else begin
            state_d = ST_FCS;
            cnt_d   = 11'd0;
          end
        end
      end
      ST_PAD: begin
        txen_d = 1'b1;
        crc_d  = crc_next;
        if (cnt_q == 11'(MIN_LEN - 1)) begin
          state_d = ST_FCS;
          cnt_d   = 11'd0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      ST_FCS: begin
        txen_d = 1'b1;
        txd_d  = crc_fcs[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q == 11'd3) begin
          state_d = ST_GAP;
          cnt_d   = 11'd0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 11'(IFG)) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          frames_d = frames_q + 32'd1;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      ST_DROP: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        if (drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
      end
      ST_DONE: begin
        // Wait for the host to drop the level so a stale slot is not resent.
        if (!bus.slot_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      wcur_q   <= '0;
      wnxt_q   <= '0;
      crc_q    <= CRC_INIT;
      addr_q   <= '0;
      txd_q    <= '0;
      txen_q   <= 1'b0;
      done_q   <= 1'b0;
      frames_q <= '0;
      drops_q  <= '0;
      prime_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      wcur_q   <= wcur_d;
      wnxt_q   <= wnxt_d;
      crc_q    <= crc_d;
      addr_q   <= addr_d;
      txd_q    <= txd_d;
      txen_q   <= txen_d;
      done_q   <= done_d;
      frames_q <= frames_d;
      drops_q  <= drops_d;
      prime_q  <= 1'b1;
    end
  end

  assign bus.gmii_txd   = txd_q;
  assign bus.gmii_tx_en = txen_q;
  assign bus.slot_done  = done_q;
  assign bus.ram_addr   = addr_q;
  assign tx_busy        = (state_q != ST_IDLE);
  assign tx_frames      = frames_q;
  assign tx_drops       = drops_q;
endmodule

// File: tb/tb_tx_slot2gmii.sv
// Bench for tx_slot2gmii: slot RAM model, GMII capture monitor, a
// frame-level reference model (byte list + bit-serial CRC), a vector
// table, hand-written corner sequences and randomized frames.
module tb_tx_slot2gmii;
  localparam int IFG = 12;
  localparam int MINL = 60;
  localparam int MAXL = 1514;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        tx_enable;
  logic        tx_busy;
  logic [31:0] tx_frames;
  logic [15:0] tx_drops;

  tx_slot2gmii_if bus ();

  tx_slot2gmii #(.IFG(IFG), .MIN_LEN(MINL), .MAX_LEN(MAXL)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_enable(tx_enable),
    .bus(bus), .tx_busy(tx_busy), .tx_frames(tx_frames), .tx_drops(tx_drops));

  always #4 sys_clk = ~sys_clk;

  logic [15:0] mem [0:4095];
  always @(posedge sys_clk) bus.ram_q <= mem[bus.ram_addr];

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // GMII / slot_done monitor, sampled on the falling edge
  logic [7:0] cap[$];
  int runs, done_cnt, first_en_cyc, last_en_cyc, done_cyc;
  logic prev_en = 1'b0;
  initial forever begin
    @(negedge sys_clk);
    if (bus.gmii_tx_en === 1'b1) begin
      cap.push_back(bus.gmii_txd);
      if (!prev_en) begin runs++; first_en_cyc = cyc; end
      last_en_cyc = cyc;
    end
    if (bus.slot_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    prev_en = (bus.gmii_tx_en === 1'b1);
  end

  int n_chk = 0, n_err = 0;
  int exp_frames = 0, exp_drops = 0;
  logic [7:0] dbytes [0:2047];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // Reference: what the wire should carry for a slot of length L
  task automatic build_exp(input int L);
    logic [31:0] c;
    int n;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    n = (L < MINL) ? MINL : L;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = (i < L) ? dbytes[i] : 8'h00;
      exp_q.push_back(b);
      c = crc_step(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
  endtask

  task automatic load_slot(input int L, input int pat);
    logic [4:0] junk;
    junk = 5'($urandom);
    mem[0] = {junk, L[10:0]};
    for (int i = 0; i < L + 2; i++) begin
      logic [7:0] b;
      b = (pat == 0 && i < L) ? i[7:0] : 8'($urandom);
      if (i < L) dbytes[i] = b;
      if (i[0]) mem[1 + i/2][7:0] = b;
      else      mem[1 + i/2][15:8] = b;
    end
  endtask

  task automatic clr_mon();
    cap.delete();
    runs = 0; done_cnt = 0; first_en_cyc = 0; last_en_cyc = 0; done_cyc = 0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin @(negedge sys_clk); n++; end
    n_chk++;
    if (done_cnt == 0) begin
      n_err++;
      $display("FAIL %s_timeout: no slot_done after %0d cycles", tag, n);
    end
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic check_frame(input string tag, input int L, input bit drop,
                             input int exp_en, input int t0);
    logic [31:0] c;
    int bad;
    if (drop) begin
      chk({tag, "_drop_en"}, cap.size(), 0);
      if (t0 >= 0) chk({tag, "_drop_t"}, done_cyc, t0 + 1);
      if (exp_drops != 16'hFFFF) exp_drops++;
    end else begin
      build_exp(L);
      chk({tag, "_en_len"}, cap.size(), exp_en);
      chk({tag, "_en_runs"}, runs, 1);
      if (t0 >= 0) chk({tag, "_first_t"}, first_en_cyc, t0);
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i >= cap.size()) bad++;
        else if (cap[i] !== exp_q[i]) bad++;
      end
      chk({tag, "_bytes_bad"}, bad, 0);
      c = 32'hFFFFFFFF;
      for (int i = 8; i < cap.size(); i++) c = crc_step(c, cap[i]);
      chk({tag, "_residue"}, c, 32'hDEBB20E3);
      chk({tag, "_gap"}, done_cyc - last_en_cyc, IFG + 1);
      exp_frames++;
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_frames"}, tx_frames, exp_frames);
    chk({tag, "_drops"}, tx_drops, exp_drops);
  endtask

  task automatic run_frame(input string tag, input int L, input int pat,
                           input bit drop, input int exp_en, input bit keep);
    int t0;
    load_slot(L, pat);
    clr_mon();
    @(negedge sys_clk);
    bus.slot_ready = 1'b1;
    t0 = cyc + 1;
    wait_done(tag);
    check_frame(tag, L, drop, exp_en, t0);
    if (!keep) begin
      bus.slot_ready = 1'b0;
      repeat (3) @(negedge sys_clk);
    end
  endtask

  typedef struct { int len; int pat; bit drop; int en; } vec_t;
  vec_t tbl[10];

  initial begin
    int n, t0, last1, L;
    tbl[0] = '{64, 0, 1'b0, 76};
    tbl[1] = '{9, 1, 1'b0, 72};
    tbl[2] = '{1600, 1, 1'b1, 0};
    tbl[3] = '{60, 1, 1'b0, 72};
    tbl[4] = '{61, 1, 1'b0, 73};
    tbl[5] = '{0, 0, 1'b0, 72};
    tbl[6] = '{1, 1, 1'b0, 72};
    tbl[7] = '{1514, 1, 1'b0, 1526};
    tbl[8] = '{1515, 1, 1'b1, 0};
    tbl[9] = '{2047, 0, 1'b1, 0};

    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    sys_rst_n = 1'b0; tx_enable = 1'b1; bus.slot_ready = 1'b0;
    clr_mon();
    repeat (3) @(negedge sys_clk);
    chk("rst_tx_en", bus.gmii_tx_en, 0);
    chk("rst_txd", bus.gmii_txd, 0);
    chk("rst_done", bus.slot_done, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_frames", tx_frames, 0);
    chk("rst_drops", tx_drops, 0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    for (int i = 0; i < 10; i++)
      run_frame($sformatf("vec%0d_L%0d", i, tbl[i].len), tbl[i].len, tbl[i].pat,
                tbl[i].drop, tbl[i].en, 1'b0);

    // Held-high ready, then a quick low/high: spacing and no stale resend
    run_frame("b2b1", 9, 1, 1'b0, 72, 1'b1);
    last1 = last_en_cyc;
    bus.slot_ready = 1'b0;
    @(negedge sys_clk);
    clr_mon();
    bus.slot_ready = 1'b1;
    wait_done("b2b2");
    chk("b2b_spacing_ok", (first_en_cyc - last1) >= IFG + 2, 1);
    check_frame("b2b2", 9, 1'b0, 72, -1);
    repeat (40) @(negedge sys_clk);
    chk("held_no_tx", cap.size(), 72);
    chk("held_done", done_cnt, 1);
    chk("held_busy", tx_busy, 1);
    bus.slot_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("held_release_idle", tx_busy, 0);

    // tx_enable dropped mid-frame
    load_slot(100, 1);
    clr_mon();
    @(negedge sys_clk);
    bus.slot_ready = 1'b1;
    t0 = cyc + 1;
    n = 0;
    while (cap.size() < 30 && n < 300) begin @(negedge sys_clk); n++; end
    tx_enable = 1'b0;
    wait_done("ena_mid");
    check_frame("ena_mid", 100, 1'b0, 112, t0);
    bus.slot_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    load_slot(20, 1);
    clr_mon();
    bus.slot_ready = 1'b1;
    repeat (100) @(negedge sys_clk);
    chk("ena_block_tx", cap.size(), 0);
    chk("ena_block_busy", tx_busy, 0);
    tx_enable = 1'b1;
    t0 = cyc + 1;
    wait_done("ena_resume");
    check_frame("ena_resume", 20, 1'b0, 72, t0);
    bus.slot_ready = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Randomized slots against the reference model
    for (int k = 0; k < 6; k++) begin
      L = $urandom_range(0, 1600);
      run_frame($sformatf("rnd%0d_L%0d", k, L), L, 1, L > MAXL,
                8 + ((L < MINL) ? MINL : L) + 4, 1'b0);
    end

    // Async reset during data byte ~20, then clean restart
    load_slot(64, 1);
    clr_mon();
    @(negedge sys_clk);
    bus.slot_ready = 1'b1;
    n = 0;
    while (cap.size() < 29 && n < 200) begin @(negedge sys_clk); n++; end
    #1 sys_rst_n = 1'b0;
    #1;
    chk("abort_tx_en", bus.gmii_tx_en, 0);
    chk("abort_txd", bus.gmii_txd, 0);
    chk("abort_busy", tx_busy, 0);
    chk("abort_frames", tx_frames, 0);
    chk("abort_addr", bus.ram_addr, 0);
    repeat (3) @(negedge sys_clk);
    chk("abort_no_done", done_cnt, 0);
    exp_frames = 0; exp_drops = 0;
    clr_mon();
    sys_rst_n = 1'b1;
    wait_done("abort_restart");
    check_frame("abort_restart", 64, 1'b0, 76, -1);
    bus.slot_ready = 1'b0;
    repeat (3) @(negedge sys_clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tx_slot2gmii.md
# tx_slot2gmii

Transmit-side engine for one ethpipe port: the mirror of the RX slot path.
- Waits for the host to fill a TX slot in dual-port RAM (port B side) and raise the slot's ready bit.
- Reads the slot, emits preamble/SFD, payload, zero padding and a computed FCS on GMII, enforces the inter-frame gap, then pulses `slot_done` so the status bit is cleared.
- Sits between the TX slot RAM (clocked by `phyN_125M_clk`) and the `phyN_tx_data`/`phyN_tx_en` pins.

## Interface
- `IFG`, 12: inter-frame gap in byte times, minimum 12.
- `MIN_LEN`, 60: minimum frame length in bytes, excluding FCS; shorter frames are zero-padded.
- `MAX_LEN`, 1514: maximum frame length in bytes, excluding FCS; longer frames are dropped.
- `sys_clk`  in  1  GMII transmit clock, 125 MHz.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `tx_enable`  in  1  enable new frames; a frame already in progress always completes.
- `slot_ready`  in  1  level, host has filled the slot; already in the `sys_clk` domain.
- `slot_done`  out  1  one-cycle pulse after the gap completes, or on a drop.
- `ram_addr`  out  12  slot RAM word address, registered.
- `ram_q`  in  16  slot RAM read data, valid 1 cycle after `ram_addr`.
- `gmii_txd`  out  8  GMII data, registered.
- `gmii_tx_en`  out  1  GMII enable, registered.
- `tx_busy`  out  1  high in every state except IDLE.
- `tx_frames`  out  32  count of frames transmitted, wraps.
- `tx_drops`  out  16  count of oversize slots dropped, saturates at 0xFFFF.

## Operation
- Slot format:
  - Word 0 bits [10:0] hold L, the frame length in bytes without FCS; bits [15:11] are ignored.
  - Words 1..ceil(L/2) hold data. Byte order is `[15:8]` first, then `[7:0]`.
  - For odd L, `[7:0]` of the last word is unused.
- States and transitions:
  - IDLE → PRE when `tx_enable & slot_ready`, if MIN_LEN ≤ L ≤ MAX_LEN or L < MIN_LEN (L < MIN_LEN is padded, not dropped).
  - IDLE → DROP when `tx_enable & slot_ready` and L > MAX_LEN.
  - PRE: 7 bytes 0x55 then 0xD5 → DATA.
  - DATA → PAD if L < MIN_LEN, otherwise → FCS.
  - PAD: bytes 0x00 until MIN_LEN bytes have been sent → FCS.
  - FCS: 4 bytes → GAP.
  - GAP: IFG cycles with `tx_en` = 0 → DONE.
  - DROP → DONE in 1 cycle, no GMII activity.
  - DONE → IDLE once `slot_ready` is sampled low. This prevents retransmitting a stale slot.
- `ram_addr` is held at 0 in IDLE, so `ram_q` already holds word 0 when `slot_ready` is sampled.
- Data words are prefetched during PRE. The word register is double-buffered so DATA streams one byte per cycle without bubbles.
- FCS is IEEE 802.3 CRC-32:
  - Reflected, init 0xFFFFFFFF, final value complemented.
  - Computed over data and pad bytes only, not preamble/SFD.
  - Sent least-significant byte first.
- `slot_done` pulses for one cycle on entering DONE. `tx_frames` increments at the same edge for frames sent on GMII; `tx_drops` increments for DROP.
- `tx_enable` low blocks only the IDLE exit.
- Reset: all outputs go to 0 asynchronously, including a frame aborted mid-transmission, and state returns to IDLE. No `slot_done` is generated for the aborted slot.

## Timing
- Cycle T: IDLE samples `slot_ready` = 1. The first 0x55 appears at T+1, SFD at T+8, and data byte 0 at T+9.
- `gmii_tx_en` is high for exactly 8 + max(L, MIN_LEN) + 4 consecutive cycles.
- This is followed by exactly IFG cycles of `tx_en` = 0, then the `slot_done` pulse.
- Back-to-back: if `slot_ready` falls and rises again, the next preamble starts no earlier than IFG + 2 cycles after the last FCS byte.
- A drop produces `slot_done` at T+2.

## Structure
- Shared package `ethpipe_pkg`:
  - state enum;
  - preamble byte 0x55 and SFD byte 0xD5;
  - CRC init value 0xFFFFFFFF and residue constant 0xDEBB20E3;
  - MIN_LEN/MAX_LEN defaults.
- One sub-module, `crc32_d8`: combinational one-byte reflected CRC-32 update (`crc_in`, `d` → `crc_out`), reused by the RX-side checker.
- The top level holds the FSM, byte counter, word prefetch buffer and statistics counters.

## Test plan
- L = 64, data 0x00..0x3F:
  - `tx_en` high for 76 cycles; bytes are 0x55×7, 0xD5, 0x00..0x3F;
  - CRC residue over data + FCS is 0xDEBB20E3;
  - `slot_done` pulses 12 cycles after `tx_en` falls; `tx_frames` = 1.
- L = 9, odd length and short:
  - 9 data bytes, then 51 bytes 0x00, then FCS; `tx_en` high for 72 cycles;
  - residue check passes.
- L = 1600:
  - no `tx_en` activity; `slot_done` at T+2; `tx_drops` = 1; `tx_frames` unchanged.
- `slot_ready` held high after `slot_done`: no second frame is sent. Lower it and raise it again → the second frame's preamble starts at least IFG + 2 cycles after the first frame's last FCS byte.
- `sys_rst_n` asserted during data byte 20:
  - `gmii_tx_en`/`gmii_txd` go to 0 immediately; no `slot_done`;
  - after release with `slot_ready` still high, the frame restarts cleanly from the preamble.
- `tx_enable` dropped mid-frame: the frame completes; a new `slot_ready` is ignored until `tx_enable` returns high.
